// File: rtl/wb_submit_arbiter.sv
// -----------------------------------------------------------------------------
// wb_submit_arbiter
//   Result-side front end of the ROB submit port. Completed results from the
//   ALU reservation station and the load/store buffer are queued in small
//   per-source FIFOs. A round-robin arbiter drains the FIFO heads and drives
//   at most one registered {submit_tag, submit_val, submit_valid} per cycle.
//   predict_fail flushes both FIFOs; rdy_in low freezes every register.
//
// Ports
//   clk_in, rst_in_n          clock / async active-low reset
//   rdy_in                    global ready, low = pause
//   alu_valid/ready/tag/val   ALU result offer and FIFO-has-room
//   lsb_valid/ready/tag/val   LSB result offer and FIFO-has-room
//   predict_fail              mispredict flush
//   submit_tag/val/valid      registered result toward the ROB
// -----------------------------------------------------------------------------
module wb_submit_arbiter #(
  parameter int unsigned TAG_W        = 4,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned FIFO_DEPTH_W = 1
) (
  input  logic              clk_in,
  input  logic              rst_in_n,
  input  logic              rdy_in,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [TAG_W-1:0]  alu_tag,
  input  logic [DATA_W-1:0] alu_val,
  input  logic              lsb_valid,
  output logic              lsb_ready,
  input  logic [TAG_W-1:0]  lsb_tag,
  input  logic [DATA_W-1:0] lsb_val,
  input  logic              predict_fail,
  output logic [TAG_W-1:0]  submit_tag,
  output logic [DATA_W-1:0] submit_val,
  output logic              submit_valid
);

  localparam int unsigned CNT_W = FIFO_DEPTH_W + 1;
  localparam int unsigned ENT_W = TAG_W + DATA_W;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  // FIFO storage: {tag, value} per entry
  logic [ENT_W-1:0]        alu_mem [FIFO_DEPTH];
  logic [ENT_W-1:0]        lsb_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH_W-1:0] alu_rd_ptr, alu_wr_ptr;
  logic [FIFO_DEPTH_W-1:0] lsb_rd_ptr, lsb_wr_ptr;
  logic [CNT_W-1:0]        alu_cnt, lsb_cnt;
  logic [CNT_W-1:0]        alu_cnt_nxt, lsb_cnt_nxt;

  // High when the LSB head wins a tie (ALU was granted last)
  logic rr_prefer_lsb;

  logic             alu_push, lsb_push;
  logic             alu_has, lsb_has;
  logic             grant_alu, grant_lsb;
  logic [ENT_W-1:0] alu_head, lsb_head;

  // Room check uses the registered count only; a same-edge pop does not free a slot early
  assign alu_ready = rst_in_n && rdy_in && (alu_cnt != CNT_FULL);
  assign lsb_ready = rst_in_n && rdy_in && (lsb_cnt != CNT_FULL);

  assign alu_head = alu_mem[alu_rd_ptr];
  assign lsb_head = lsb_mem[lsb_rd_ptr];

  // Push/grant qualification; a flush discards both
  always_comb begin
    alu_push  = alu_valid && alu_ready && !predict_fail;
    lsb_push  = lsb_valid && lsb_ready && !predict_fail;
    alu_has   = (alu_cnt != '0);
    lsb_has   = (lsb_cnt != '0);
    grant_alu = rdy_in && !predict_fail && alu_has && (!lsb_has || !rr_prefer_lsb);
    grant_lsb = rdy_in && !predict_fail && lsb_has && (!alu_has || rr_prefer_lsb);
  end

  // Occupancy update; simultaneous push and pop leaves the count unchanged
  always_comb begin
    alu_cnt_nxt = alu_cnt;
    lsb_cnt_nxt = lsb_cnt;
    if (alu_push && !grant_alu) begin
      alu_cnt_nxt = alu_cnt + CNT_W'(1);
    end else if (!alu_push && grant_alu) begin
      alu_cnt_nxt = alu_cnt - CNT_W'(1);
    end
    if (lsb_push && !grant_lsb) begin
      lsb_cnt_nxt = lsb_cnt + CNT_W'(1);
    end else if (!lsb_push && grant_lsb) begin
      lsb_cnt_nxt = lsb_cnt - CNT_W'(1);
    end
  end

  // Entry storage carries no reset; validity is tracked by the counts
  always_ff @(posedge clk_in) begin
    if (alu_push) begin
      alu_mem[alu_wr_ptr] <= {alu_tag, alu_val};
    end
    if (lsb_push) begin
      lsb_mem[lsb_wr_ptr] <= {lsb_tag, lsb_val};
    end
  end

  // Pointers, counts, arbiter state and the submit register
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      alu_rd_ptr    <= '0;
      alu_wr_ptr    <= '0;
      lsb_rd_ptr    <= '0;
      lsb_wr_ptr    <= '0;
      alu_cnt       <= '0;
      lsb_cnt       <= '0;
      rr_prefer_lsb <= 1'b0;
      submit_tag    <= '0;
      submit_val    <= '0;
      submit_valid  <= 1'b0;
    end else if (rdy_in) begin
      if (predict_fail) begin
        // Flush: arbiter fairness state is deliberately kept
        alu_rd_ptr   <= '0;
        alu_wr_ptr   <= '0;
        lsb_rd_ptr   <= '0;
        lsb_wr_ptr   <= '0;
        alu_cnt      <= '0;
        lsb_cnt      <= '0;
        submit_valid <= 1'b0;
      end else begin
        // Power-of-two depth: pointer overflow is the wrap
        if (alu_push) begin
          alu_wr_ptr <= alu_wr_ptr + FIFO_DEPTH_W'(1);
        end
        if (lsb_push) begin
          lsb_wr_ptr <= lsb_wr_ptr + FIFO_DEPTH_W'(1);
        end
        alu_cnt <= alu_cnt_nxt;
        lsb_cnt <= lsb_cnt_nxt;

        if (grant_alu) begin
          alu_rd_ptr    <= alu_rd_ptr + FIFO_DEPTH_W'(1);
          submit_tag    <= alu_head[ENT_W-1:DATA_W];
          submit_val    <= alu_head[DATA_W-1:0];
          submit_valid  <= 1'b1;
          rr_prefer_lsb <= 1'b1;
        end else if (grant_lsb) begin
          lsb_rd_ptr    <= lsb_rd_ptr + FIFO_DEPTH_W'(1);
          submit_tag    <= lsb_head[ENT_W-1:DATA_W];
          submit_val    <= lsb_head[DATA_W-1:0];
          submit_valid  <= 1'b1;
          rr_prefer_lsb <= 1'b0;
        end else begin
          submit_valid  <= 1'b0;
        end
      end
    end
  end

endmodule
